// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store sequencer in front of a word-wide Data_Memory.
// Byte/half/word loads use lane extraction plus sign/zero extension. Sub-word
// stores use a read-modify-write of the containing word. The unit stalls the
// pipeline while busy.
// Optional feature macro: MEM_ACCESS_MISALIGN_TRAP_EN
//   defined   -> misaligned requests complete via ERR with misalign_o = 1
//   undefined -> misaligned addresses are forced down to the natural
//                alignment and the access proceeds; misalign_o stays 0
module mem_access_unit #(
  parameter int unsigned MEM_LAT = 1   // read strobe hold cycles, 1..15
) (
  input  logic        Clock_i,
  input  logic        Reset_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        misalign_o,
  output logic        stall_o,
  output logic        MemRead_o,
  output logic        MemWrite_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    RMW  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4,
    ERR  = 3'd5
  } state_t;

  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  // True when the offset violates the natural alignment of the access size.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic r;
    case (size)
      2'b00:   r = 1'b0;
      2'b01:   r = off[0];
      default: r = (off != 2'b00);
    endcase
    return r;
  endfunction

  // Clears the offset bits that a misaligned half or word is not allowed to use.
  function automatic logic [31:0] force_align(input logic [31:0] a, input logic [1:0] size);
    logic [31:0] r;
    case (size)
      2'b00:   r = a;
      2'b01:   r = {a[31:1], 1'b0};
      default: r = {a[31:2], 2'b00};
    endcase
    return r;
  endfunction

  // Picks the addressed lane(s) out of a memory word and extends to 32 bits.
  function automatic logic [31:0] extract_lane(input logic [31:0] w, input logic [1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'b00:   b = w[7:0];
      2'b01:   b = w[15:8];
      2'b10:   b = w[23:16];
      default: b = w[31:24];
    endcase
    if (off[1]) begin
      h = w[31:16];
    end else begin
      h = w[15:0];
    end
    case (size)
      2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Inserts right-aligned store data into the addressed lane(s) of a word.
  function automatic logic [31:0] merge_lane(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] off, input logic [1:0] size);
    logic [31:0] r;
    r = w;
    case (size)
      2'b00: begin
        case (off)
          2'b00:   r[7:0]   = d[7:0];
          2'b01:   r[15:8]  = d[7:0];
          2'b10:   r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      2'b01: begin
        if (off[1]) begin
          r[31:16] = d[15:0];
        end else begin
          r[15:0] = d[15:0];
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  state_t      state_q;
  logic [3:0]  cnt_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  off_q;
  logic [31:0] wdata_q;
  logic        ready_q;
  logic        resp_valid_q;
  logic [31:0] resp_rdata_q;
  logic        misalign_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;

  logic        req_misalign_s;
  logic        trap_s;
  logic [31:0] eff_addr_d;

  // Decode the incoming request: alignment check and effective address.
  always_comb begin
    req_misalign_s = is_misaligned(req_size_i, req_addr_i[1:0]);
    if (TRAP_EN) begin
      trap_s     = req_misalign_s;
      eff_addr_d = req_addr_i;
    end else begin
      trap_s     = 1'b0;
      eff_addr_d = req_misalign_s ? force_align(req_addr_i, req_size_i) : req_addr_i;
    end
  end

  // Sequencer FSM with all outputs registered; reset drops strobes at once.
  always_ff @(posedge Clock_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
      off_q        <= 2'b00;
      wdata_q      <= 32'h0000_0000;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0000_0000;
      misalign_q   <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= 32'h0000_0000;
      mem_wdata_q  <= 32'h0000_0000;
    end else begin
      case (state_q)
        IDLE: begin
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
          if (req_valid_i) begin
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            off_q   <= eff_addr_d[1:0];
            wdata_q <= req_wdata_i;
            ready_q <= 1'b0;
            if (trap_s) begin
              state_q      <= ERR;
              resp_valid_q <= 1'b1;
              misalign_q   <= 1'b1;
              resp_rdata_q <= 32'h0000_0000;
            end else begin
              mem_addr_q <= {eff_addr_d[31:2], 2'b00};
              if (!req_write_i) begin
                state_q    <= RD;
                mem_read_q <= 1'b1;
                cnt_q      <= LAT_M1;
              end else if (req_size_i[1]) begin
                state_q     <= WR;
                mem_write_q <= 1'b1;
                mem_wdata_q <= req_wdata_i;
              end else begin
                state_q    <= RMW;
                mem_read_q <= 1'b1;
                cnt_q      <= LAT_M1;
              end
            end
          end else begin
            ready_q <= 1'b1;
          end
        end
        RD: begin
          if (cnt_q == 4'd0) begin
            mem_read_q   <= 1'b0;
            resp_rdata_q <= extract_lane(mem_rdata_i, off_q, size_q, uns_q);
            resp_valid_q <= 1'b1;
            state_q      <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RMW: begin
          if (cnt_q == 4'd0) begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b1;
            mem_wdata_q <= merge_lane(mem_rdata_i, wdata_q, off_q, size_q);
            state_q     <= WR;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        WR: begin
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b1;
          resp_rdata_q <= 32'h0000_0000;
          state_q      <= RESP;
        end
        RESP: begin
          resp_valid_q <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
        ERR: begin
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
        default: begin
          mem_read_q   <= 1'b0;
          mem_write_q  <= 1'b0;
          resp_valid_q <= 1'b0;
          misalign_q   <= 1'b0;
          ready_q      <= 1'b1;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  // The completion cycle releases the stall so the pipeline takes the result.
  assign stall_o = ((state_q != IDLE) && (state_q != RESP) && (state_q != ERR)) ||
                   ((state_q == IDLE) && req_valid_i);

  assign req_ready_o  = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_rdata_o = resp_rdata_q;
  assign misalign_o   = misalign_q & TRAP_EN;
  assign MemRead_o    = mem_read_q;
  assign MemWrite_o   = mem_write_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;

endmodule
